// File: rtl/hazard_stall_unit.sv
// D-stage stall generator for the 5-stage MIPS pipeline: E/M producer shadows, Tuse/Tnew compare, mult/div busy timer.
// Optional stall_cnt performance counter is built when HAZARD_STALL_PERF_EN is defined.

module hazard_operand_cmp #(
    parameter logic [1:0] TUSE_NONE = 2'd3
) (
    input  logic [4:0] addr_i,
    input  logic [1:0] tuse_i,
    input  logic [4:0] a3_e_i,
    input  logic       rw_e_i,
    input  logic [1:0] tnew_e_i,
    input  logic [4:0] a3_m_i,
    input  logic       rw_m_i,
    input  logic [1:0] tnew_m_i,
    output logic       hit_o
);

    logic used;
    logic hit_e;
    logic hit_m;

    assign used  = (tuse_i != TUSE_NONE);
    assign hit_e = rw_e_i && (a3_e_i != 5'd0) && (a3_e_i == addr_i) && (tuse_i < tnew_e_i);
    assign hit_m = rw_m_i && (a3_m_i != 5'd0) && (a3_m_i == addr_i) && (tuse_i < tnew_m_i);
    assign hit_o = used && (hit_e || hit_m);

endmodule

module hazard_stall_unit #(
    parameter int         MULT_CYCLES = 5,
    parameter int         DIV_CYCLES  = 10,
    parameter logic [1:0] TUSE_NONE   = 2'd3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  a1_d,
    input  logic [4:0]  a2_d,
    input  logic [4:0]  a3_d,
    input  logic        regwrite_d,
    input  logic [1:0]  tuse_rs_d,
    input  logic [1:0]  tuse_rt_d,
    input  logic [1:0]  tnew_d,
    input  logic        mdu_use_d,
    input  logic [1:0]  mdu_op_d,
    output logic        stall,
    output logic        flush_e,
    output logic        mdu_busy,
    output logic        mdu_start_e
`ifdef HAZARD_STALL_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int         NUM_OPS  = 2;
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;

    typedef struct packed {
        logic [4:0] a3;
        logic       rw;
        logic [1:0] tnew;
    } prod_t;

    prod_t      e_q, e_d;
    prod_t      m_q, m_d;
    logic [1:0] e_op_q, e_op_d;
    logic [3:0] cnt_q, cnt_d;

    logic [NUM_OPS-1:0][4:0] op_addr;
    logic [NUM_OPS-1:0][1:0] op_tuse;
    logic [NUM_OPS-1:0]      op_hit;
    logic                    mdu_hazard;

    assign op_addr = {a2_d, a1_d};
    assign op_tuse = {tuse_rt_d, tuse_rs_d};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        hazard_operand_cmp #(
            .TUSE_NONE (TUSE_NONE)
        ) u_cmp (
            .addr_i   (op_addr[g]),
            .tuse_i   (op_tuse[g]),
            .a3_e_i   (e_q.a3),
            .rw_e_i   (e_q.rw),
            .tnew_e_i (e_q.tnew),
            .a3_m_i   (m_q.a3),
            .rw_m_i   (m_q.rw),
            .tnew_m_i (m_q.tnew),
            .hit_o    (op_hit[g])
        );
    end

    assign mdu_start_e = (e_op_q != OP_NONE);
    assign mdu_busy    = (cnt_q != 4'd0) || mdu_start_e;
    assign mdu_hazard  = mdu_use_d && mdu_busy;
    assign stall       = (|op_hit) || mdu_hazard;
    assign flush_e     = stall;

    // A stalled D instruction must not advance, so E takes a bubble instead.
    always_comb begin
        e_d    = '0;
        e_op_d = OP_NONE;
        if (!stall) begin
            e_d.a3   = a3_d;
            e_d.rw   = regwrite_d;
            e_d.tnew = tnew_d;
            e_op_d   = (mdu_op_d == 2'b11) ? OP_NONE : mdu_op_d;
        end
    end

    always_comb begin
        m_d      = e_q;
        m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
    end

    // The most recent start always wins, even over a countdown in progress.
    always_comb begin
        cnt_d = cnt_q;
        if (e_op_q == OP_MULT) begin
            cnt_d = 4'(MULT_CYCLES);
        end else if (e_op_q == OP_DIV) begin
            cnt_d = 4'(DIV_CYCLES);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q    <= '0;
            m_q    <= '0;
            e_op_q <= OP_NONE;
            cnt_q  <= 4'd0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            e_op_q <= e_op_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed pipeline pairs plus random traffic against a timeline model.
// Build with HAZARD_STALL_PERF_EN defined to also cover the stall_cnt counter.

module tb_hazard_stall_unit;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] a1_d, a2_d, a3_d;
    logic       regwrite_d;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       mdu_use_d;
    logic [1:0] mdu_op_d;
    logic       stall, flush_e, mdu_busy, mdu_start_e;
`ifdef HAZARD_STALL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    hazard_stall_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a1_d        (a1_d),
        .a2_d        (a2_d),
        .a3_d        (a3_d),
        .regwrite_d  (regwrite_d),
        .tuse_rs_d   (tuse_rs_d),
        .tuse_rt_d   (tuse_rt_d),
        .tnew_d      (tnew_d),
        .mdu_use_d   (mdu_use_d),
        .mdu_op_d    (mdu_op_d),
        .stall       (stall),
        .flush_e     (flush_e),
        .mdu_busy    (mdu_busy),
        .mdu_start_e (mdu_start_e)
`ifdef HAZARD_STALL_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] a1, a2, a3;
        logic       rw;
        logic [1:0] tuse_rs, tuse_rt, tnew;
        logic       mdu_use;
        logic [1:0] op;
    } instr_t;

    typedef struct packed {
        logic stall, flush, busy, start;
    } exp_t;

    exp_t   sb_q[$];
    instr_t hist[$];      // instructions that entered E, newest last (age 0 = E, age 1 = M)
    int     checks = 0, failures = 0;
    int     cyc = 0, free_cyc = -1, exp_stall_cnt = 0;
    int     dut_stalls = 0, dut_busy = 0, dut_starts = 0;

    function automatic instr_t mk(int a1, int a2, int a3, int rw, int trs, int trt,
                                  int tnew, int mu, int op);
        instr_t i;
        i.a1 = 5'(a1); i.a2 = 5'(a2); i.a3 = 5'(a3); i.rw = 1'(rw);
        i.tuse_rs = 2'(trs); i.tuse_rt = 2'(trt); i.tnew = 2'(tnew);
        i.mdu_use = 1'(mu); i.op = 2'(op);
        return i;
    endfunction

    // Operand is late if the producer's remaining latency exceeds the consumer's slack.
    function automatic bit late(instr_t p, int age, logic [4:0] a, logic [1:0] tuse);
        int rem;
        if (!p.rw || p.a3 == 5'd0 || p.a3 != a) return 1'b0;
        rem = int'(p.tnew) - age;
        if (rem < 0) rem = 0;
        return int'(tuse) < rem;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(instr_t'(0));
        hist.push_back(instr_t'(0));
        free_cyc = -1;
        exp_stall_cnt = 0;
    endtask

    task automatic drive(input instr_t d);
        a1_d = d.a1; a2_d = d.a2; a3_d = d.a3; regwrite_d = d.rw;
        tuse_rs_d = d.tuse_rs; tuse_rt_d = d.tuse_rt; tnew_d = d.tnew;
        mdu_use_d = d.mdu_use; mdu_op_d = d.op;
    endtask

    // One clock of D-stage presentation; returns the modelled stall decision.
    task automatic step(input instr_t d, output bit st);
        instr_t pe, pm;
        bit start, busy, haz;
        exp_t e;
        drive(d);
        pe = hist[hist.size()-1];
        pm = hist[hist.size()-2];
        start = (pe.op == 2'b01) || (pe.op == 2'b10);
        if (start) free_cyc = cyc + ((pe.op == 2'b01) ? MULT_CYC : DIV_CYC);
        busy = (cyc <= free_cyc);
        haz = late(pe, 0, d.a1, d.tuse_rs) || late(pm, 1, d.a1, d.tuse_rs) ||
              late(pe, 0, d.a2, d.tuse_rt) || late(pm, 1, d.a2, d.tuse_rt);
        st = haz || (d.mdu_use && busy);
        e.stall = st; e.flush = st; e.busy = busy; e.start = start;
        sb_q.push_back(e);
        hist.push_back(st ? instr_t'(0) : d);
        hist.delete(0);
        if (st) exp_stall_cnt++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input instr_t d);
        bit st;
        int n;
        n = 0;
        do begin
            step(d, st);
            n++;
        end while (st && n < 64);
    endtask

    // Monitor: DUT presents a decision every cycle; compare it mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({stall, flush_e, mdu_busy, mdu_start_e} !== e) begin
                failures++;
                $display("FAIL cycle%0d stall/flush/busy/start: got %b expected %b",
                         cyc, {stall, flush_e, mdu_busy, mdu_start_e}, e);
            end
        end
        if (reset_n) begin
            if (stall)       dut_stalls++;
            if (mdu_busy)    dut_busy++;
            if (mdu_start_e) dut_starts++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        instr_t nop, lw8, beq8, add9, add_r9, beq9, lw0, beq0, dv, mflo, mul_nu, r;
        int s0, b0, t0;
        bit st;

        nop    = mk(0, 0, 0, 0, 3, 3, 0, 0, 0);
        lw8    = mk(1, 0, 8, 1, 1, 3, 2, 0, 0);
        beq8   = mk(8, 0, 0, 0, 0, 0, 0, 0, 0);
        add9   = mk(1, 2, 9, 1, 1, 1, 1, 0, 0);
        add_r9 = mk(9, 3, 4, 1, 1, 1, 1, 0, 0);
        beq9   = mk(9, 0, 0, 0, 0, 0, 0, 0, 0);
        lw0    = mk(1, 0, 0, 1, 1, 3, 2, 0, 0);
        beq0   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        dv     = mk(4, 5, 0, 0, 1, 1, 0, 1, 2);
        mflo   = mk(0, 0, 10, 1, 3, 3, 1, 1, 0);
        mul_nu = mk(4, 5, 0, 0, 1, 1, 0, 0, 1);

        reset_n = 1'b0;
        drive(nop);
        model_reset();
        #3;
        chk("reset_stall", int'(stall), 0);
        chk("reset_flush_e", int'(flush_e), 0);
        chk("reset_mdu_busy", int'(mdu_busy), 0);
        chk("reset_mdu_start_e", int'(mdu_start_e), 0);
        #9 reset_n = 1'b1;
        @(posedge clk);
        #1;
`ifdef HAZARD_STALL_PERF_EN
        chk("stall_cnt_after_reset", int'(stall_cnt), 0);
`endif

        for (int k = 0; k < 2; k++) begin
            s0 = dut_stalls;
            issue(lw8);
            issue(beq8);
            chk("lw_beq_stall_cycles", dut_stalls - s0, 2);
            issue(nop);
            issue(nop);
        end
`ifdef HAZARD_STALL_PERF_EN
        chk("stall_cnt_lw_beq_twice", int'(stall_cnt), 4);
`endif

        s0 = dut_stalls;
        issue(add9); issue(add_r9);
        chk("alu_alu_forwarded", dut_stalls - s0, 0);
        issue(nop); issue(nop);

        s0 = dut_stalls;
        issue(add9); issue(beq9);
        chk("alu_beq_stall_cycles", dut_stalls - s0, 1);
        issue(nop); issue(nop);

        s0 = dut_stalls;
        issue(lw0); issue(beq0);
        chk("reg0_no_stall", dut_stalls - s0, 0);
        issue(nop); issue(nop);

        s0 = dut_stalls;
        t0 = dut_starts;
        issue(dv); issue(mflo);
        chk("div_mflo_stall_cycles", dut_stalls - s0, 1 + DIV_CYC);
        chk("div_start_pulse_cycles", dut_starts - t0, 1);
        issue(nop); issue(nop);

        // mult lands in E with the div countdown at 7 and restarts the timer
        b0 = dut_busy;
        issue(dv);
        for (int k = 0; k < 3; k++) issue(nop);
        issue(mul_nu);
        for (int k = 0; k < 12; k++) issue(nop);
        chk("mult_reload_busy_cycles", dut_busy - b0, 4 + 1 + MULT_CYC);

        for (int k = 0; k < 400; k++) begin
            r = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? 1 : 0,
                   ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
            issue(r);
        end
        for (int k = 0; k < 12; k++) issue(nop);

        // asynchronous reset in the middle of a div countdown
        issue(dv);
        for (int k = 0; k < 3; k++) step(mflo, st);
        #2;
        chk("busy_before_async_reset", int'(mdu_busy), 1);
        chk("stall_before_async_reset", int'(stall), 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_stall", int'(stall), 0);
        chk("async_reset_mdu_busy", int'(mdu_busy), 0);
        chk("async_reset_mdu_start_e", int'(mdu_start_e), 0);
`ifdef HAZARD_STALL_PERF_EN
        chk("async_reset_stall_cnt", int'(stall_cnt), 0);
`endif
        model_reset();
        drive(nop);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;

        for (int k = 0; k < 150; k++) begin
            r = mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), ($urandom_range(0, 5) == 0) ? 1 : 0,
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
            issue(r);
        end
        issue(nop);
`ifdef HAZARD_STALL_PERF_EN
        chk("stall_cnt_total", int'(stall_cnt), exp_stall_cnt);
`endif
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Producer-side companion to the forwarding selector in the 5-stage MIPS pipeline.
- Keeps a shadow copy of every in-flight producer in E and M: destination register, write enable, remaining Tnew.
- Compares each producer against the D-stage consumer's Tuse and raises a stall when forwarding cannot yet supply the operand.
- Owns the multi-cycle mult/div busy timer. D-stage MDU instructions wait until HI/LO are free.

Parameters:
MULT_CYCLES, 5, busy cycles loaded when a mult/multu enters E
DIV_CYCLES, 10, busy cycles loaded when a div/divu enters E
TUSE_NONE, 3, Tuse code meaning "operand not read"

Ports:
clk  input  1  pipeline clock
reset_n  input  1  asynchronous active-low reset
a1_d  input  5  rs index of D instruction
a2_d  input  5  rt index of D instruction
a3_d  input  5  destination index of D instruction
regwrite_d  input  1  D instruction writes GRF
tuse_rs_d  input  2  cycles until rs is needed (0 = D-stage, TUSE_NONE = unused)
tuse_rt_d  input  2  as above for rt
tnew_d  input  2  cycles from E entry until result is forwardable (0 = PC-link, 1 = ALU, 2 = DM)
mdu_use_d  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
mdu_op_d  input  2  00 none, 01 mult/multu, 10 div/divu, 11 reserved (treated as 00)
stall  output  1  freeze PC and D register
flush_e  output  1  insert bubble into E register (equals stall)
mdu_busy  output  1  HI/LO result pending
mdu_start_e  output  1  E holds a mult/div (start pulse to MDU)

Behaviour:
- Clock and reset: single clock `clk`. Reset `reset_n` is asynchronous, active-low.
- Reset clears all shadow registers (a3 = 0, regwrite = 0, tnew = 0, mdu_op = 00) and the busy counter.
- Outputs after reset: stall = 0, flush_e = 0, mdu_busy = 0, mdu_start_e = 0.
- Reset asserted mid-operation aborts any pending busy count immediately.
- Shadow E register updates every rising edge:
  - stall = 0: loads {a3_d, regwrite_d, tnew_d, mdu_op_d}.
  - stall = 1: loads a bubble (regwrite = 0, a3 = 0, tnew = 0, mdu_op = 00).
- Shadow M register loads from E every edge: tnew_m = (tnew_e == 0) ? 0 : tnew_e − 1, with no wrap below 0.
- W needs no shadow: its Tnew is always 0 and forwarding covers it.
- Register hazard, per operand X ∈ {rs, rt} with index aX_d:
  - hit_e = regwrite_e && a3_e != 0 && a3_e == aX_d && tuse_X_d < tnew_e
  - hit_m = same comparison against the M shadow.
  - tuse = TUSE_NONE never stalls (3 ≥ any tnew).
  - Register $0 never stalls.
- MDU timer:
  - A 4-bit down counter.
  - On an edge where shadow E holds op 01, it loads MULT_CYCLES; op 10 loads DIV_CYCLES.
  - Otherwise it decrements if nonzero.
  - A new start while already busy reloads the counter (the later op wins).
- mdu_start_e = (shadow mdu_op_e != 00), combinational from the register.
- mdu_busy = (count != 0) || mdu_start_e.
- MDU hazard = mdu_use_d && mdu_busy.
- stall = any register hazard || MDU hazard. It is purely combinational from current shadows and D inputs, with zero-cycle latency.
- A single stall lasts until the producer's Tnew drops enough or busy clears. Maximum durations:
  - Register hazard: 2 cycles (lw→beq).
  - MDU hazard: DIV_CYCLES + 1 cycles.

Optional Feature:
Macro HAZARD_STALL_PERF_EN.
- Defined: adds output stall_cnt [31:0].
  - Increments on every clock edge where stall = 1 and wraps at 2^32.
  - Cleared by reset_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- lw $8 in E (tnew 2), D is beq using $8 (tuse_rs 0):
  - stall = 1 for 2 cycles.
  - flush_e = 1 both cycles.
  - stall = 0 on the third.
- addu $9 in E (tnew 1), D is addu reading $9 (tuse 1): stall = 0 (forwarded).
- Same pair with D as beq (tuse 0): exactly 1 stall cycle.
- lw $0 in E, D is beq on $0: stall = 0.
- div enters E, mflo follows in D:
  - mdu_start_e pulses 1 cycle.
  - stall held for 11 cycles (1 + DIV_CYCLES).
  - Released when count reaches 0.
- mult in E with count at 7 from an earlier div: counter reloads to 5, mdu_busy stays 1.
- Assert reset_n = 0 during a div countdown: mdu_busy, stall and mdu_start_e drop to 0 immediately, without a clock edge.
- With HAZARD_STALL_PERF_EN defined, run the lw/beq case twice: stall_cnt = 4.
